// File: rtl/yuv422_pkg.sv
// Shared types for the YUV422 capture stage: FSM encoding, pixel record and error bit positions.
package yuv422_pkg;

  localparam int unsigned PIX_COORD_W = 12;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_LINE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_B0,
    S_B1,
    S_B2,
    S_B3
  } state_t;

  typedef struct packed {
    logic [7:0]             y;
    logic [7:0]             u;
    logic [7:0]             v;
    logic [PIX_COORD_W-1:0] row;
    logic [PIX_COORD_W-1:0] col;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module pixel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/yuv422_capture.sv
// Regroups the sensor's byte-serial YUV422 stream into one pixel (Y plus shared U/V, row/col)
// per transfer, buffered through a small FIFO with a valid/ready output.
module yuv422_capture
  import yuv422_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 3264,
  parameter int unsigned IMG_HEIGHT = 2448,
  parameter int unsigned COORD_W    = PIX_COORD_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          UYVY       = 1'b0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               vsync,
  input  logic               href,
  input  logic               pix_strobe,
  input  logic [7:0]         pix_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [7:0]         Y,
  output logic [7:0]         U,
  output logic [7:0]         V,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               frame_done,
  output logic [1:0]         err
);

  localparam logic [COORD_W-1:0] W_C  = COORD_W'(IMG_WIDTH);
  localparam logic [COORD_W-1:0] H_C  = COORD_W'(IMG_HEIGHT);
  localparam logic [COORD_W-1:0] WL_C = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] HL_C = COORD_W'(IMG_HEIGHT - 1);

  state_t             state, state_nx;
  logic               vsync_d, href_d;
  logic               vsync_rise, href_fall, byte_in;
  logic               grp_done, grp_ok, line_end;
  logic [7:0]         b0, b1, b2;
  logic [7:0]         y0_b, y1_b, u_b, v_b;
  logic [COORD_W-1:0] row_cnt, col_cnt;
  pixel_t             even_pix, odd_pix, pend, head, wdata;
  logic               pend_valid, push, pop, fifo_full, fifo_empty;

  assign vsync_rise = vsync && !vsync_d;
  assign href_fall  = href_d && !href;
  assign byte_in    = href && pix_strobe;

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next state; a vsync rise restarts the frame from any state, dropping a partial group.
  always_comb begin
    state_nx = state;
    grp_done = 1'b0;
    line_end = 1'b0;
    if (vsync_rise) begin
      state_nx = S_WAIT_LINE;
    end else if (state != S_IDLE && href_fall) begin
      state_nx = S_WAIT_LINE;
      line_end = 1'b1;
    end else if (byte_in) begin
      case (state)
        S_WAIT_LINE, S_B0: state_nx = S_B1;
        S_B1:              state_nx = S_B2;
        S_B2:              state_nx = S_B3;
        S_B3: begin
          state_nx = S_B0;
          grp_done = 1'b1;
        end
        default:           state_nx = state;
      endcase
    end
  end

  // The 4th byte is taken live from pix_data so the even pixel is pushed on its strobe cycle.
  always_comb begin
    if (UYVY) begin
      u_b  = b0;
      y0_b = b1;
      v_b  = b2;
      y1_b = pix_data;
    end else begin
      y0_b = b0;
      u_b  = b1;
      y1_b = b2;
      v_b  = pix_data;
    end
  end

  assign grp_ok   = grp_done && (col_cnt < W_C) && (row_cnt < H_C);
  assign even_pix = '{y: y0_b, u: u_b, v: v_b,
                      row: PIX_COORD_W'(row_cnt), col: PIX_COORD_W'(col_cnt)};
  assign odd_pix  = '{y: y1_b, u: u_b, v: v_b,
                      row: PIX_COORD_W'(row_cnt), col: PIX_COORD_W'(col_cnt + COORD_W'(1))};

  assign push  = grp_ok || pend_valid;
  assign wdata = pend_valid ? pend : even_pix;
  assign pop   = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vsync_d    <= 1'b0;
      href_d     <= 1'b0;
      b0         <= '0;
      b1         <= '0;
      b2         <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      err        <= '0;
      frame_done <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      href_d     <= href;
      pend_valid <= grp_ok;
      if (grp_ok) pend <= odd_pix;

      if (byte_in) begin
        case (state)
          S_WAIT_LINE, S_B0: b0 <= pix_data;
          S_B1:              b1 <= pix_data;
          S_B2:              b2 <= pix_data;
          default:           ;
        endcase
      end

      // Coordinates: row saturates at IMG_HEIGHT so trailing lines are recognisable and dropped.
      if (vsync_rise) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (line_end) begin
        col_cnt <= '0;
        if (row_cnt < H_C) row_cnt <= row_cnt + COORD_W'(1);
      end else if (grp_ok) begin
        col_cnt <= col_cnt + COORD_W'(2);
      end

      if (push && fifo_full && !pop) err[ERR_OVF] <= 1'b1;
      if ((grp_done && !grp_ok) ||
          (line_end && ((col_cnt != W_C) || (state inside {S_B1, S_B2, S_B3}))))
        err[ERR_LINE] <= 1'b1;

      frame_done <= pop && (row == HL_C) && (col == WL_C);
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_t))
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .wdata  (wdata),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign Y         = head.y;
  assign U         = head.u;
  assign V         = head.v;
  assign row       = COORD_W'(head.row);
  assign col       = COORD_W'(head.col);

endmodule
